// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile: MIPS write-back stage and 32x32 general-purpose register file.
//   Selects the write-back result, commits it to the register file, serves the
//   two decode-stage read ports and counts committed register writes.
//
// Build option:
//   WB_BYPASS_EN  when defined, a read port whose index matches the register
//                 being committed this cycle returns ResultW in the same cycle.
//
// Ports:
//   Clk        in   1   pipeline clock, state updates on posedge
//   Reset      in   1   asynchronous active-high reset
//   RegWriteW  in   1   write enable from MEM/WB
//   MemtoRegW  in   2   result select: 0 ALU, 1 load data, 2 link addr, 3 zero
//   ALUOutW    in   32  ALU result
//   ReadDataW  in   32  load data
//   PCPlus8W   in   32  link address for jal/jalr
//   WriteRegW  in   5   destination register index
//   RA1D       in   5   read port 1 index (rs)
//   RA2D       in   5   read port 2 index (rt)
//   RD1D       out  32  read port 1 data (combinational)
//   RD2D       out  32  read port 2 data (combinational)
//   ResultW    out  32  selected write-back value (combinational)
//   WbCount    out  32  committed register writes since reset (registered)
// -----------------------------------------------------------------------------
module wb_regfile (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RegWriteW,
    input  logic [1:0]  MemtoRegW,
    input  logic [31:0] ALUOutW,
    input  logic [31:0] ReadDataW,
    input  logic [31:0] PCPlus8W,
    input  logic [4:0]  WriteRegW,
    input  logic [4:0]  RA1D,
    input  logic [4:0]  RA2D,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [31:0] ResultW,
    output logic [31:0] WbCount
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              commit;

    // Write-back result select; code 3 is reserved and yields zero.
    always_comb begin
        ResultW = '0;
        case (MemtoRegW)
            2'd0:    ResultW = ALUOutW;
            2'd1:    ResultW = ReadDataW;
            2'd2:    ResultW = PCPlus8W;
            default: ResultW = '0;
        endcase
    end

    // Register 0 is hard-wired, so writes to it are not commits.
    assign commit = RegWriteW && (WriteRegW != ADDR_W'(0));

    // Register file and retired-write counter; entry 0 is never written.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            WbCount <= '0;
        end else if (commit) begin
            regs[WriteRegW] <= ResultW;
            WbCount         <= WbCount + DATA_W'(1);
        end
    end

    // Read ports. Bypass is suppressed during reset so reads stay at zero.
    always_comb begin
        RD1D = '0;
        RD2D = '0;
        if (RA1D != ADDR_W'(0)) begin
            RD1D = regs[RA1D];
`ifdef WB_BYPASS_EN
            if (commit && !Reset && (RA1D == WriteRegW)) begin
                RD1D = ResultW;
            end
`endif
        end
        if (RA2D != ADDR_W'(0)) begin
            RD2D = regs[RA2D];
`ifdef WB_BYPASS_EN
            if (commit && !Reset && (RA2D == WriteRegW)) begin
                RD2D = ResultW;
            end
`endif
        end
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general-purpose register file for the five-stage MIPS pipeline. Consumes the W-stage signals leaving the MEM/WB pipeline register, selects the write-back result, commits it to a 32×32 register file and serves the two decode-stage read ports. Also keeps a retired-write counter for bench and debug use.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register index, 32 registers.
- Clk  input  1  pipeline clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- RegWriteW  input  1  write enable from MEM/WB.
- MemtoRegW  input  2  result select: 0 ALUOutW, 1 ReadDataW, 2 PCPlus8W, 3 reserved.
- ALUOutW  input  32  ALU result.
- ReadDataW  input  32  load data.
- PCPlus8W  input  32  link address for jal/jalr.
- WriteRegW  input  5  destination register index.
- RA1D  input  5  read port 1 index (rs).
- RA2D  input  5  read port 2 index (rt).
- RD1D  output  32  read port 1 data.
- RD2D  output  32  read port 2 data.
- ResultW  output  32  selected write-back value, also used by the forwarding muxes.
- WbCount  output  32  number of committed register writes since reset.

## Operation
- Result select is combinational: MemtoRegW 0→ALUOutW, 1→ReadDataW, 2→PCPlus8W, 3→32'b0.
- Commit condition: RegWriteW=1 and WriteRegW≠0. On posedge Clk with commit, register[WriteRegW] <= ResultW and WbCount <= WbCount+1.
- Writes to register 0 are discarded and do not increment WbCount. Register 0 always reads 0.
- When RegWriteW=0, no register changes and WbCount holds.
- Read ports are combinational and independent. A read of index 0 returns 0 regardless of any write.
- Read/write same-cycle hazard: controlled by WB_BYPASS_EN (see Configuration).
- WbCount wraps from 32'hFFFFFFFF to 0 with no flag.
- Reset, asserted at any time including mid-cycle: all 32 registers, and WbCount, go to 0 immediately and asynchronously. RD1D and RD2D then read 0. ResultW remains a pure function of its inputs.
- While Reset is high, posedge Clk commits nothing.
- Deasserting Reset between edges takes effect at the next posedge.

## Timing
- Write latency: 1 edge. The value is visible on the read ports after the commit edge, or in the same cycle with bypass.
- Read latency: 0 cycles; combinational from RA1D/RA2D and register contents.
- ResultW: 0 cycles, combinational from the W-stage inputs.
- Output reset values:
  - RD1D=0 and RD2D=0 (all registers are zero).
  - WbCount=0.
  - ResultW follows its inputs.
- No handshake. The block accepts one write per cycle unconditionally. Stalls and flushes are expressed upstream by zeroing RegWriteW.

## Configuration
- WB_BYPASS_EN defined:
  - A read port whose index equals WriteRegW, while the commit condition holds, returns ResultW combinationally in the same cycle.
  - This covers the D/W hazard without a forwarding path in the hazard unit.
- WB_BYPASS_EN undefined:
  - Read ports return the stored register value only. Same-cycle reads see the old value.
  - The hazard unit must forward ResultW to decode or stall one cycle.
- Index 0 never bypasses, in either build.

## Test plan
- Reset then read all 32 indices → every RD1D/RD2D = 0 and WbCount = 0.
- RegWriteW=1, MemtoRegW=0, ALUOutW=32'h1234_5678, WriteRegW=8; next cycle RA1D=8 → RD1D=32'h1234_5678, WbCount=1. Repeat with MemtoRegW=1 (ReadDataW=32'hDEAD_BEEF) and MemtoRegW=2 (PCPlus8W=32'h0000_3008) to registers 9 and 31 → those values read back, WbCount=3.
- RegWriteW=1, WriteRegW=0, ALUOutW=32'hFFFF_FFFF; RA2D=0 → RD2D=0 both during and after the edge, WbCount unchanged.
- Same cycle: RegWriteW=1, WriteRegW=5, ALUOutW=32'hAAAA_0005, RA1D=5.
  - With WB_BYPASS_EN: RD1D=32'hAAAA_0005 before the edge.
  - Without WB_BYPASS_EN: RD1D=old value (0) before the edge, 32'hAAAA_0005 after it.
- Write register 3 = 32'h0000_0077. Pulse Reset for 2 ns between clock edges → RD1D (RA1D=3) drops to 0 before the next posedge, and WbCount=0. A write presented while Reset is high is not committed.
- MemtoRegW=3 with RegWriteW=1, WriteRegW=4, nonzero data inputs → ResultW=0, register 4 reads 0, WbCount increments.
